scope_dec_mch: RTL

//  Multi-channel stream decimator for the scope acquisition path, between the ADC/filter stage and the trigger/buffer stage.

---
 rtl/scope_dec_mch_pkg.sv | 37 +++
 rtl/scope_dec_mch_if.sv | 17 +
 rtl/scope_dec_mch_lane.sv | 100 ++++++++++
 rtl/scope_dec_mch.sv | 134 +++++++++++++
 4 files changed

// File: rtl/scope_dec_mch_pkg.sv
// Shared types and helpers for the scope_dec_mch multi-channel decimator.
// Holds the decimation mode enum, the default accumulator width and a
// width-generic saturation helper used by every lane.
package scope_dec_pkg;

    typedef enum logic [1:0] {
        DEC_SAMPLE = 2'd0,
        DEC_AVG    = 2'd1,
        DEC_MAX    = 2'd2,
        DEC_MIN    = 2'd3
    } dec_mode_t;

    localparam int IW_DEF  = 16;
    localparam int DCW_DEF = 17;
    // Accumulator width: one input lane summed over the longest window.
    localparam int AW      = IW_DEF + DCW_DEF;

    // Working width of the saturation helper; callers sign-extend into it,
    // so any input width up to SAT_W is handled.
    localparam int SAT_W   = 64;

    // Clamp a signed value to the range of an ow-bit signed number.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                    input int ow);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (x > max_v)
            sat = max_v;
        else if (x < min_v)
            sat = min_v;
        else
            sat = x;
    endfunction

endpackage

// File: rtl/scope_dec_mch_if.sv
// AXI4-Stream style bundle carrying DN signed lanes of W bits per beat.
// TKEEP has one bit per lane. Modport s/master drives data, d/slave sinks it.
interface axi4_stream_if #(
    parameter int DN = 2,
    parameter int W  = 16
);
    logic                   TVALID;
    logic                   TREADY;
    logic [DN-1:0][W-1:0]   TDATA;
    logic [DN-1:0]          TKEEP;
    logic                   TLAST;

    modport s      (output TVALID, TDATA, TKEEP, TLAST, input  TREADY);
    modport d      (input  TVALID, TDATA, TKEEP, TLAST, output TREADY);
    modport master (output TVALID, TDATA, TKEEP, TLAST, input  TREADY);
    modport slave  (input  TVALID, TDATA, TKEEP, TLAST, output TREADY);
endinterface

// File: rtl/scope_dec_mch_lane.sv
// One decimator lane: running sum, running extreme, AVG shift (optionally
// rounded when SCOPE_DEC_MCH_ROUND_EN is defined) and saturation to OW bits.
// res is combinational and valid on the last beat of a window; the top
// level registers it.
module scope_dec_lane
    import scope_dec_pkg::*;
#(
    parameter int IW  = 16,
    parameter int OW  = 16,
    parameter int DCW = 17,
    parameter int DSW = 5
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  ctl_rst,
    input  logic                  beat,
    input  logic                  first,
    input  logic                  last,
    input  dec_mode_t             mode,
    input  logic [DSW-1:0]        shr,
    input  logic signed [IW-1:0]  din,
    output logic signed [OW-1:0]  res
);

    localparam int LAW = IW + DCW;

    logic signed [LAW-1:0] acc_reg;
    logic signed [LAW-1:0] acc_next;
    logic signed [IW-1:0]  ext_reg;
    logic signed [IW-1:0]  ext_next;
    logic signed [LAW-1:0] din_ext;
    logic signed [SAT_W-1:0] pre_sat;

    assign din_ext = {{DCW{din[IW-1]}}, din};

    // Window state including the current beat; the first beat seeds both.
    always_comb begin
        acc_next = acc_reg + din_ext;
        ext_next = ext_reg;
        if (first) begin
            acc_next = din_ext;
            ext_next = din;
        end else if (mode == DEC_MIN) begin
            if (din < ext_reg) ext_next = din;
        end else begin
            if (din > ext_reg) ext_next = din;
        end
    end

`ifdef SCOPE_DEC_MCH_ROUND_EN
    localparam int VW = LAW + 1;
    logic signed [VW-1:0] avg_val;
    logic signed [VW-1:0] rnd_bias;
    logic signed [VW-1:0] rnd_sum;
    // Round half up: add half of the shifted-out LSB weight, one bit wider so no overflow.
    always_comb begin
        rnd_bias = '0;
        if (shr != '0) rnd_bias = VW'(1) << (shr - DSW'(1));
        rnd_sum  = {acc_next[LAW-1], acc_next} + rnd_bias;
        avg_val  = rnd_sum >>> shr;
    end
`else
    localparam int VW = LAW;
    logic signed [VW-1:0] avg_val;
    // Plain arithmetic shift, truncating toward -inf.
    always_comb avg_val = acc_next >>> shr;
`endif

    // Pick the mode result, widen it and clamp it into the output width.
    always_comb begin
        pre_sat = {{(SAT_W-IW){din[IW-1]}}, din};
        case (mode)
            DEC_AVG:          pre_sat = {{(SAT_W-VW){avg_val[VW-1]}}, avg_val};
            DEC_MAX, DEC_MIN: pre_sat = {{(SAT_W-IW){ext_next[IW-1]}}, ext_next};
            default:          ;
        endcase
    end

    assign res = OW'(sat(pre_sat, OW));

    // Accumulator/extreme registers; cleared on abort and at each window end.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            acc_reg <= '0;
            ext_reg <= '0;
        end else if (ctl_rst) begin
            acc_reg <= '0;
            ext_reg <= '0;
        end else if (beat) begin
            if (last) begin
                acc_reg <= '0;
                ext_reg <= '0;
            end else begin
                acc_reg <= acc_next;
                ext_reg <= ext_next;
            end
        end
    end

endmodule

// File: rtl/scope_dec_mch.sv
// Multi-channel stream decimator: reduces each of DN lanes over windows of
// cfg_dec+1 beats (sample/average/max/min), with backpressure, sticky TLAST,
// ANDed TKEEP and per-window config latching.
// Optional macro SCOPE_DEC_MCH_ROUND_EN enables round-half-up in AVG mode.
module scope_dec_mch
    import scope_dec_pkg::*;
#(
    parameter int DN  = 2,
    parameter int IW  = 16,
    parameter int OW  = 16,
    parameter int DCW = 17,
    parameter int DSW = 5
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic            ctl_rst,
    input  logic [1:0]      cfg_mode,
    input  logic [DCW-1:0]  cfg_dec,
    input  logic [DSW-1:0]  cfg_shr,
    axi4_stream_if.d        sti,
    axi4_stream_if.s        sto
);

    logic [DCW-1:0]         cnt_reg;
    dec_mode_t              mode_q;
    logic [DCW-1:0]         dec_q;
    logic [DSW-1:0]         shr_q;
    logic                   last_reg;
    logic [DN-1:0]          keep_reg;

    logic                   sto_valid_reg;
    logic [DN-1:0][OW-1:0]  sto_data_reg;
    logic                   sto_last_reg;
    logic [DN-1:0]          sto_keep_reg;

    logic                   sti_ready;
    logic                   beat;
    logic                   first;
    logic                   last;
    logic                   win_done;
    dec_mode_t              mode_eff;
    logic [DCW-1:0]         dec_eff;
    logic [DSW-1:0]         shr_eff;
    logic                   tlast_win;
    logic [DN-1:0]          keep_win;
    logic [DN-1:0][OW-1:0]  lane_res;

    // Window bookkeeping; the first beat of a window sees the live config
    // because that is the beat on which it gets latched.
    always_comb begin
        sti_ready = ~sto_valid_reg | sto.TREADY;
        beat      = sti.TVALID & sti_ready & ~ctl_rst;
        first     = (cnt_reg == '0);
        mode_eff  = first ? dec_mode_t'(cfg_mode) : mode_q;
        dec_eff   = first ? cfg_dec : dec_q;
        shr_eff   = first ? cfg_shr : shr_q;
        last      = (cnt_reg == dec_eff);
        win_done  = beat & last;
        tlast_win = sti.TLAST | (~first & last_reg);
        keep_win  = first ? sti.TKEEP : (keep_reg & sti.TKEEP);
    end

    assign sti.TREADY = sti_ready;
    assign sto.TVALID = sto_valid_reg;
    assign sto.TDATA  = sto_data_reg;
    assign sto.TLAST  = sto_last_reg;
    assign sto.TKEEP  = sto_keep_reg;

    // Beat counter, config latch and sticky TLAST/TKEEP for the open window.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_reg  <= '0;
            mode_q   <= DEC_SAMPLE;
            dec_q    <= '0;
            shr_q    <= '0;
            last_reg <= 1'b0;
            keep_reg <= '0;
        end else if (ctl_rst) begin
            cnt_reg  <= '0;
            last_reg <= 1'b0;
            keep_reg <= '0;
        end else if (beat) begin
            if (first) begin
                mode_q <= mode_eff;
                dec_q  <= dec_eff;
                shr_q  <= shr_eff;
            end
            cnt_reg  <= last ? '0 : cnt_reg + DCW'(1);
            last_reg <= tlast_win;
            keep_reg <= keep_win;
        end
    end

    // Output register: loaded when a window closes, held while stalled.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            sto_valid_reg <= 1'b0;
            sto_data_reg  <= '0;
            sto_last_reg  <= 1'b0;
            sto_keep_reg  <= '0;
        end else if (win_done) begin
            sto_valid_reg <= 1'b1;
            sto_data_reg  <= lane_res;
            sto_last_reg  <= tlast_win;
            sto_keep_reg  <= keep_win;
        end else if (sto.TREADY) begin
            sto_valid_reg <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DN; gi++) begin : g_lane
            scope_dec_lane #(
                .IW  (IW),
                .OW  (OW),
                .DCW (DCW),
                .DSW (DSW)
            ) u_lane (
                .ACLK    (ACLK),
                .ARESETn (ARESETn),
                .ctl_rst (ctl_rst),
                .beat    (beat),
                .first   (first),
                .last    (last),
                .mode    (mode_eff),
                .shr     (shr_eff),
                .din     (sti.TDATA[gi]),
                .res     (lane_res[gi])
            );
        end
    endgenerate

endmodule
